// File: rtl/mmc1_pkg.sv
// rtl/mmc1_pkg.sv - shared types and constants for the MMC1 serial loader
package mmc1_pkg;

  typedef logic [1:0] reg_sel_t;

  localparam reg_sel_t REG_CTRL = 2'd0;
  localparam reg_sel_t REG_CHR0 = 2'd1;
  localparam reg_sel_t REG_CHR1 = 2'd2;
  localparam reg_sel_t REG_PRG  = 2'd3;

  localparam int SHIFT_LEN = 5;

  typedef struct packed {
    logic     nromsel;
    logic     rnw;
    reg_sel_t sel;
    logic     d7;
    logic     d0;
  } bus_snap_t;

  function automatic logic is_rom_write(input bus_snap_t s);
    return !s.nromsel && !s.rnw;
  endfunction

endpackage

// File: rtl/mmc1_sync.sv
// rtl/mmc1_sync.sv - multi-bit, multi-stage input synchronizer with sync reset
module mmc1_sync #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/mmc1_serial_loader.sv
// rtl/mmc1_serial_loader.sv - CPU bus sampler and MMC1 5-bit serial load protocol
module mmc1_serial_loader
  import mmc1_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       CLK,
  input  logic       RES,
  input  logic       M2,
  input  logic       nROMSEL,
  input  logic       CPU_RnW,
  input  logic       CPU_A14,
  input  logic       CPU_A13,
  input  logic       CPU_D7,
  input  logic       CPU_D0,
  output logic       REG_WE,
  output logic [1:0] REG_SEL,
  output logic [4:0] REG_DATA,
  output logic       CTRL_RESET,
  output logic [2:0] SHIFT_CNT
);

  logic [6:0] bus_s;
  logic       m2_s;
  logic       m2_d;
  logic       fall;
  logic       prev_wr;
  logic       rom_wr;
  logic [3:0] shift;
  bus_snap_t  bus_now;
  bus_snap_t  snap;

  // One synchronizer for every bus bit keeps M2 and the data aligned.
  mmc1_sync #(
    .WIDTH(7),
    .DEPTH(SYNC_STAGES)
  ) u_sync (
    .clk(CLK),
    .rst(RES),
    .d  ({M2, nROMSEL, CPU_RnW, CPU_A14, CPU_A13, CPU_D7, CPU_D0}),
    .q  (bus_s)
  );

  assign m2_s    = bus_s[6];
  assign bus_now = bus_snap_t'(bus_s[5:0]);
  assign fall    = m2_d & ~m2_s;
  assign rom_wr  = is_rom_write(snap);

  always_ff @(posedge CLK) begin
    if (RES) begin
      m2_d       <= 1'b0;
      snap       <= '0;
      prev_wr    <= 1'b0;
      shift      <= '0;
      SHIFT_CNT  <= '0;
      REG_WE     <= 1'b0;
      CTRL_RESET <= 1'b0;
      REG_SEL    <= REG_CTRL;
      REG_DATA   <= '0;
    end else begin
      m2_d       <= m2_s;
      REG_WE     <= 1'b0;
      CTRL_RESET <= 1'b0;
      if (m2_s) snap <= bus_now;
      if (fall) begin
        prev_wr <= rom_wr;
        // A write directly following a write (RMW dummy cycle) is dropped.
        if (rom_wr && !prev_wr) begin
          if (snap.d7) begin
            shift      <= '0;
            SHIFT_CNT  <= '0;
            CTRL_RESET <= 1'b1;
          end else if (SHIFT_CNT == 3'(SHIFT_LEN - 1)) begin
            REG_DATA  <= {snap.d0, shift};
            REG_SEL   <= snap.sel;
            REG_WE    <= 1'b1;
            shift     <= '0;
            SHIFT_CNT <= '0;
          end else begin
            shift[SHIFT_CNT[1:0]] <= snap.d0;
            SHIFT_CNT             <= SHIFT_CNT + 3'd1;
          end
        end
      end
    end
  end

endmodule
